ov5640_pixel_packer: RTL and testbench
======================================

# ov5640_pixel_packer

Downstream of the camera byte-to-pixel stage, in the camera pixel-clock domain. Accepts one RGB565 pixel per write strobe and packs four pixels into one 64-bit word. Tags each word with start-of-frame, end-of-line and end-of-frame flags using programmed frame geometry. Buffers words in a small FIFO behind a valid/ready master port feeding the frame-buffer writer. The camera cannot be stalled, so FIFO overflow drops words and is flagged.

## Interface
- H_PIXELS, 1024: active pixels per line; multiple of 4, at least 4.
- V_LINES, 768: active lines per frame, at least 1.
- FIFO_DEPTH, 8: word FIFO entries; power of 2, at least 2.

- ov5640_pclk  in  1  pixel clock; all logic on rising edge.
- sys_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- ov5640_vsync  in  1  camera frame sync; the rising edge marks frame start.
- ov5640_wr_en  in  1  pixel strobe from the byte-to-pixel stage.
- ov5640_data_out  in  16  RGB565 pixel, valid when ov5640_wr_en=1.
- m_data  out  64  packed word; pixel 0 in [15:0], pixel 3 in [63:48].
- m_sof  out  1  word is the first word of the frame.
- m_eol  out  1  word holds the last pixel of a line.
- m_eof  out  1  word holds the last pixel of the frame (m_eol also 1).
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts the word when m_valid and m_ready are both 1.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- frame_err  out  1  sticky: short frame or excess pixels seen.

## Operation
- vsync_q register; vs_rise = ov5640_vsync & ~vsync_q.
- FSM states:
  - WAIT_VS, the reset state: ignore pixels. Go to ACTIVE on vs_rise.
  - ACTIVE: pack pixels. Go to DONE when the pixel completing the last word of the frame is sampled.
  - DONE: on a pixel strobe, set frame_err and drop the pixel. Go to ACTIVE on vs_rise.
- On every vs_rise:
  - Clear pix_cnt (0..3), x_cnt (word index in line) and y_cnt, and discard any partial word.
  - If the state is ACTIVE and at least one pixel of the frame has arrived, set frame_err (short frame).
- Packing: the 4th pixel forms the word from 3 held pixels plus the incoming pixel, then writes it with flags into the FIFO on the same edge.
  - m_sof = (x_cnt==0 && y_cnt==0).
  - m_eol = (x_cnt==H_PIXELS/4-1).
  - m_eof = m_eol && y_cnt==V_LINES-1.
  - x_cnt wraps to 0 at line end; y_cnt then increments.
- FIFO stores 67 bits (data + 3 flags). Show-ahead: the head is driven on m_data and flags.
- Full and write with no pop: the word is dropped, overflow is set, and counters still advance so geometry stays aligned. Full and write with a pop on the same edge: the write is accepted.
- overflow and frame_err clear only on sys_rst.
- Reset mid-frame: state returns to WAIT_VS, the FIFO empties, and the next vs_rise starts cleanly.

## Timing
- Reset values: m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, overflow=0, frame_err=0, state WAIT_VS, all counters 0.
- Latency: 4th pixel sampled at edge k gives m_valid=1 in the cycle after edge k, if the FIFO was empty.
- Pixel strobe in the same cycle as vs_rise: the counters clear and the pixel is ignored.
- Pop: m_valid&&m_ready at edge k; the next entry, if any, is presented after edge k with no bubble.
- Sustained throughput: 1 word per 4 pixels. m_ready may be held low up to FIFO_DEPTH words without loss.

## Structure
- Shared package ov5640_pkg:
  - PIX_W=16, WORD_W=64, PIX_PER_WORD=4.
  - FSM state enum.
  - Flag bit positions within the FIFO entry.
- Sub-module ov5640_word_fifo: synchronous show-ahead FIFO, parameterised width and depth, with full/empty, async active-high reset.
- Top level: edge detect, FSM, counters, packer registers, sticky flags.

## Test plan
Use H_PIXELS=8, V_LINES=2, FIFO_DEPTH=4.
- Reset, then pixels before any vsync -> m_valid stays 0, no flags.
- vs_rise, then 16 strobes of pixels 0xA000+n with m_ready=1 -> 4 words.
  - Word 0 = 0xA003_A002_A001_A000 with m_sof=1.
  - Word 1 with m_eol=1.
  - Word 3 with m_eol=m_eof=1.
  - frame_err=0.
- Frame of 16 pixels with m_ready=0, then release -> 4 words held; all 4 delivered in order on consecutive cycles; overflow=0.
- Two frames with m_ready=0 -> 4 words kept, words 5-8 dropped, overflow=1. The second frame's words carry no m_sof since they were dropped.
- vs_rise after 6 pixels -> frame_err=1. Partial pixels 4-5 discarded. The next frame's first word has m_sof=1.
- 17th pixel after a complete frame -> frame_err=1, no extra word.
- sys_rst mid-frame with 2 words queued -> m_valid=0 immediately, flags cleared, next frame correct.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 pixel packer: pixel/word widths,
// FIFO entry layout and the frame FSM state type.
package ov5640_pkg;

  localparam int PIX_W        = 16;
  localparam int WORD_W       = 64;
  localparam int PIX_PER_WORD = 4;

  // FIFO entry layout: packed word in the low bits, frame flags above it
  localparam int FLAG_SOF = WORD_W;
  localparam int FLAG_EOL = WORD_W + 1;
  localparam int FLAG_EOF = WORD_W + 2;
  localparam int ENTRY_W  = WORD_W + 3;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/ov5640_pixel_packer_if.sv
// Valid/ready word stream from the pixel packer to the frame-buffer writer.
interface ov5640_pixel_packer_if;
  import ov5640_pkg::*;

  logic [WORD_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data, m_sof, m_eol, m_eof, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_sof, m_eol, m_eof, m_valid,
    output m_ready
  );

endinterface

// File: rtl/ov5640_word_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always presented on rd_data;
// an empty FIFO presents zero. A write while full is accepted only when a
// pop happens on the same edge.
module ov5640_word_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status, head presentation and pointer advance for this cycle
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = rd_en && !empty;
    do_push  = wr_en && (!full || do_pop);
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only visible through a valid head pointer
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/ov5640_pixel_packer.sv
// Packs four RGB565 pixels into a 64-bit word, tags it with frame position
// flags from the programmed geometry and queues it for the frame-buffer
// writer. The camera cannot be stalled, so a full FIFO drops words.
module ov5640_pixel_packer
  import ov5640_pkg::*;
#(
  parameter int H_PIXELS   = 1024,
  parameter int V_LINES    = 768,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  ov5640_pclk,
  input  logic                  sys_rst,
  input  logic                  ov5640_vsync,
  input  logic                  ov5640_wr_en,
  input  logic [PIX_W-1:0]      ov5640_data_out,
  ov5640_pixel_packer_if.master m_if,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int WPL = H_PIXELS / PIX_PER_WORD;
  localparam int XW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int YW  = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WPL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  state_e                    state_q, state_d;
  logic                      vsync_q;
  logic                      vs_rise;
  logic [1:0]                pix_cnt_q, pix_cnt_d;
  logic [XW-1:0]             x_cnt_q, x_cnt_d;
  logic [YW-1:0]             y_cnt_q, y_cnt_d;
  logic [2:0][PIX_W-1:0]     hold_q, hold_d;
  logic                      got_pix_q, got_pix_d;
  logic                      overflow_q, overflow_d;
  logic                      frame_err_q, frame_err_d;
  logic                      word_wr;
  logic [ENTRY_W-1:0]        entry;
  logic [ENTRY_W-1:0]        head;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign vs_rise = ov5640_vsync & ~vsync_q;

  // Next-state logic: frame FSM, pixel/word/line counters, packing and sticky errors
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    hold_d      = hold_q;
    got_pix_d   = got_pix_q;
    frame_err_d = frame_err_q;
    word_wr     = 1'b0;
    entry                = '0;
    entry[WORD_W-1:0]    = {ov5640_data_out, hold_q[2], hold_q[1], hold_q[0]};
    entry[FLAG_SOF]      = (x_cnt_q == '0) && (y_cnt_q == '0);
    entry[FLAG_EOL]      = (x_cnt_q == X_LAST);
    entry[FLAG_EOF]      = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

    if (vs_rise) begin
      // A new frame always restarts geometry and throws away a partial word
      pix_cnt_d = '0;
      x_cnt_d   = '0;
      y_cnt_d   = '0;
      got_pix_d = 1'b0;
      if (state_q == ST_ACTIVE && got_pix_q) begin
        frame_err_d = 1'b1;
      end
      state_d = ST_ACTIVE;
    end else if (ov5640_wr_en) begin
      case (state_q)
        ST_ACTIVE: begin
          got_pix_d = 1'b1;
          if (pix_cnt_q == 2'd3) begin
            word_wr   = 1'b1;
            pix_cnt_d = '0;
            if (x_cnt_q == X_LAST) begin
              x_cnt_d = '0;
              if (y_cnt_q == Y_LAST) begin
                y_cnt_d = '0;
                state_d = ST_DONE;
              end else begin
                y_cnt_d = y_cnt_q + YW'(1);
              end
            end else begin
              x_cnt_d = x_cnt_q + XW'(1);
            end
          end else begin
            case (pix_cnt_q)
              2'd0:    hold_d[0] = ov5640_data_out;
              2'd1:    hold_d[1] = ov5640_data_out;
              default: hold_d[2] = ov5640_data_out;
            endcase
            pix_cnt_d = pix_cnt_q + 2'd1;
          end
        end
        ST_DONE: begin
          frame_err_d = 1'b1;
        end
        default: begin
        end
      endcase
    end

    overflow_d = overflow_q | (word_wr & fifo_full & ~m_if.m_ready);
  end

  // State, counters, holding registers and sticky flags
  always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_WAIT_VS;
      vsync_q     <= 1'b0;
      pix_cnt_q   <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      hold_q      <= '0;
      got_pix_q   <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= ov5640_vsync;
      pix_cnt_q   <= pix_cnt_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      hold_q      <= hold_d;
      got_pix_q   <= got_pix_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  ov5640_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ov5640_pclk),
    .rst     (sys_rst),
    .wr_en   (word_wr),
    .wr_data (entry),
    .rd_en   (m_if.m_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head of the FIFO drives the stream port directly
  always_comb begin
    m_if.m_data  = head[WORD_W-1:0];
    m_if.m_sof   = head[FLAG_SOF];
    m_if.m_eol   = head[FLAG_EOL];
    m_if.m_eof   = head[FLAG_EOF];
    m_if.m_valid = ~fifo_empty;
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ov5640_pixel_packer.sv
// Testbench for ov5640_pixel_packer with an 8x2 frame and a 4-deep FIFO.
// A frame-level reference model predicts every delivered word and flag.
module tb_ov5640_pixel_packer;

  localparam int H   = 8;
  localparam int V   = 2;
  localparam int DEP = 4;
  localparam int WPL = H / 4;
  localparam int WPF = WPL * V;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        vsync = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] pdata = '0;
  logic        overflow;
  logic        frame_err;

  ov5640_pixel_packer_if bus ();

  ov5640_pixel_packer #(
    .H_PIXELS   (H),
    .V_LINES    (V),
    .FIFO_DEPTH (DEP)
  ) dut (
    .ov5640_pclk     (clk),
    .sys_rst         (sys_rst),
    .ov5640_vsync    (vsync),
    .ov5640_wr_en    (wr_en),
    .ov5640_data_out (pdata),
    .m_if            (bus),
    .overflow        (overflow),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level pixel count and a bounded word queue
  int          m_state;
  int          m_npix;
  logic        m_vs_prev;
  logic        m_ovf;
  logic        m_ferr;
  logic [15:0] m_hold [4];
  logic [66:0] mq [$];
  logic [66:0] exp_q [$];
  logic [66:0] got_q [$];

  task automatic model_clear();
    m_state   = 0;
    m_npix    = 0;
    m_vs_prev = 1'b0;
    m_ovf     = 1'b0;
    m_ferr    = 1'b0;
    mq.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  // One clock of stimulus: record a DUT pop, drive inputs, advance the model
  task automatic step(input logic vs, input logic we, input logic [15:0] d, input logic rdy);
    logic        pop;
    logic        was_full;
    logic        vsr;
    int          w;
    logic [66:0] ent;
    @(negedge clk);
    if (bus.m_valid && rdy) got_q.push_back({bus.m_eof, bus.m_eol, bus.m_sof, bus.m_data});
    vsync       = vs;
    wr_en       = we;
    pdata       = d;
    bus.m_ready = rdy;
    was_full = (mq.size() == DEP);
    pop      = (mq.size() > 0) && rdy;
    if (pop) exp_q.push_back(mq.pop_front());
    vsr = vs && !m_vs_prev;
    m_vs_prev = vs;
    if (vsr) begin
      if (m_state == 1 && m_npix > 0) m_ferr = 1'b1;
      m_state = 1;
      m_npix  = 0;
    end else if (we) begin
      if (m_state == 1) begin
        m_hold[m_npix % 4] = d;
        m_npix++;
        if (m_npix % 4 == 0) begin
          w = m_npix / 4 - 1;
          ent = {(w == WPF - 1), (w % WPL == WPL - 1), (w == 0),
                 m_hold[3], m_hold[2], m_hold[1], m_hold[0]};
          if (w == WPF - 1) m_state = 2;
          if (!was_full || pop) mq.push_back(ent);
          else m_ovf = 1'b1;
        end
      end else if (m_state == 2) begin
        m_ferr = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst     = 1'b1;
    vsync       = 1'b0;
    wr_en       = 1'b0;
    bus.m_ready = 1'b0;
    model_clear();
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, rdy);
  endtask

  task automatic vs_pulse(input logic rdy);
    step(1'b0, 1'b0, 16'h0, rdy);
    step(1'b1, 1'b0, 16'h0, rdy);
    step(1'b1, 1'b0, 16'h0, rdy);
  endtask

  task automatic pixels(input int n, input int base, input logic rnd, input logic rdy);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 1'b0, 16'h0, rdy);
      step(1'b0, 1'b1, rnd ? 16'($urandom) : 16'(base + i), rdy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_head: valid=%b data=%h, want 0/0", bus.m_valid, bus.m_data);
    end
    checks++;
    if ({bus.m_sof, bus.m_eol, bus.m_eof, overflow, frame_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: sof/eol/eof/ovf/ferr=%b, want 00000",
               {bus.m_sof, bus.m_eol, bus.m_eof, overflow, frame_err});
    end
    pixels(12, 16'h5000, 1'b0, 1'b1);
    idle(3, 1'b1);
    checks++;
    if (got_q.size() != 0 || bus.m_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_vsync: words=%0d valid=%b ferr=%b, want 0/0/0",
               got_q.size(), bus.m_valid, frame_err);
    end
  endtask

  task automatic test_frame();
    do_reset();
    vs_pulse(1'b1);
    pixels(16, 16'hA000, 1'b0, 1'b1);
    idle(6, 1'b1);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL frame_count: got %0d words, want 4", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 67'h1_A003_A002_A001_A000) begin
        errors++;
        $display("[TB] FAIL frame_word0: got %h, want %h", got_q[0], 67'h1_A003_A002_A001_A000);
      end
      checks++;
      if (got_q[1][66:64] !== 3'b010 || got_q[3][66:64] !== 3'b110) begin
        errors++;
        $display("[TB] FAIL frame_flags: w1=%b w3=%b, want 010/110", got_q[1][66:64], got_q[3][66:64]);
      end
    end
    checks++;
    if (got_q != exp_q || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_model: got %0d words ferr=%b, want %0d words ferr=0",
               got_q.size(), frame_err, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    vs_pulse(1'b0);
    pixels(16, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    checks++;
    if (bus.m_valid !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_held: valid=%b ovf=%b, want 1/0", bus.m_valid, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (bus.m_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_burst: cycle %0d valid=%b, want 1", i, bus.m_valid);
      end
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b0 || got_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL bp_drained: valid=%b words=%0d, want 0/4", bus.m_valid, got_q.size());
    end
    checks++;
    if (got_q != exp_q || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_model: got %0d words ovf=%b, want %0d words ovf=0",
               got_q.size(), overflow, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    vs_pulse(1'b0);
    pixels(16, 0, 1'b1, 1'b0);
    vs_pulse(1'b0);
    pixels(16, 0, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_flag: ovf=%b ferr=%b, want 1/0", overflow, frame_err);
    end
    idle(8, 1'b1);
    checks++;
    if (got_q.size() != 4 || got_q != exp_q) begin
      errors++;
      $display("[TB] FAIL ovf_words: got %0d words, want %0d matching model", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    vs_pulse(1'b1);
    pixels(6, 16'hB000, 1'b0, 1'b1);
    vs_pulse(1'b1);
    pixels(16, 16'hC000, 1'b0, 1'b1);
    idle(6, 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_ferr: ferr=%b, want 1", frame_err);
    end
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("[TB] FAIL short_count: got %0d words, want 5", got_q.size());
    end else if (got_q[1] !== 67'h1_C003_C002_C001_C000) begin
      errors++;
      $display("[TB] FAIL short_next_sof: got %h, want %h", got_q[1], 67'h1_C003_C002_C001_C000);
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("[TB] FAIL short_model: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_excess_pixel();
    do_reset();
    vs_pulse(1'b1);
    pixels(17, 0, 1'b1, 1'b1);
    idle(6, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || got_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL excess: ferr=%b words=%0d, want 1/4", frame_err, got_q.size());
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("[TB] FAIL excess_model: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    vs_pulse(1'b0);
    pixels(10, 0, 1'b1, 1'b0);
    idle(1, 1'b0);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_queued: valid=%b, want 1", bus.m_valid);
    end
    sys_rst = 1'b1;
    wr_en   = 1'b0;
    vsync   = 1'b0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 64'h0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: valid=%b data=%h ovf=%b ferr=%b, want all 0",
               bus.m_valid, bus.m_data, overflow, frame_err);
    end
    model_clear();
    bus.m_ready = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    vs_pulse(1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
    idle(8, 1'b1);
    checks++;
    if (got_q.size() != 4 || got_q != exp_q || got_q[0][64] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_frame: got %0d words, want 4 matching model with sof first",
               got_q.size());
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      vs_pulse(1'($urandom_range(0, 1)));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    idle(10, 1'b1);
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("[TB] FAIL random_words: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (overflow !== m_ovf || frame_err !== m_ferr) begin
      errors++;
      $display("[TB] FAIL random_flags: ovf=%b ferr=%b, want %b/%b", overflow, frame_err, m_ovf, m_ferr);
    end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    model_clear();
    sys_rst = 1'b1;
    #12;
    test_reset();
    test_frame();
    test_backpressure();
    test_overflow();
    test_short_frame();
    test_excess_pixel();
    test_reset_mid_frame();
    for (int r = 0; r < 5; r++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
